// File: rtl/rob_pkg.sv
// Shared instruction-kind encodings, ROB entry layout and small helpers for the reorder buffer.
package rob_pkg;

  typedef enum logic [1:0] {
    KIND_ALU    = 2'd0,
    KIND_BRANCH = 2'd1,
    KIND_LOAD   = 2'd2,
    KIND_STORE  = 2'd3
  } kind_e;

  typedef struct packed {
    logic        valid;
    logic        done;
    kind_e       kind;
    logic [4:0]  rd;
    logic        pred_taken;
    logic        taken;
    logic [31:0] pc;
    logic [31:0] value;
    logic [31:0] aux;
  } entry_t;

  function automatic logic is_store(input kind_e k);
    return k == KIND_STORE;
  endfunction

  function automatic logic is_branch(input kind_e k);
    return k == KIND_BRANCH;
  endfunction

  function automatic int unsigned rob_tag_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/rob_commit_select.sv
// Picks how many head entries retire this cycle; a done store at the head retires alone on st_ready,
// and a mispredicted branch closes its group and requests a flush.
module rob_commit_select
  import rob_pkg::*;
#(
  parameter int COMMIT_W = 2,
  parameter int CNT_W    = $clog2(COMMIT_W + 1)
) (
  input  logic [COMMIT_W-1:0]      slot_valid,
  input  logic [COMMIT_W-1:0]      slot_done,
  input  logic [COMMIT_W-1:0][1:0] slot_kind,
  input  logic [COMMIT_W-1:0]      slot_mispredict,
  input  logic                     st_ready,
  output logic [CNT_W-1:0]         retire_cnt,
  output logic                     flush_req,
  output logic                     store_retire
);

  logic stop;

  always_comb begin
    retire_cnt   = '0;
    flush_req    = 1'b0;
    store_retire = 1'b0;
    stop         = 1'b0;
    if (slot_valid[0] && slot_done[0] && is_store(kind_e'(slot_kind[0]))) begin
      store_retire = st_ready;
      retire_cnt   = CNT_W'(st_ready);
    end else begin
      for (int k = 0; k < COMMIT_W; k++) begin
        if (!stop) begin
          if (slot_valid[k] && slot_done[k] && !is_store(kind_e'(slot_kind[k]))) begin
            retire_cnt = retire_cnt + CNT_W'(1);
            if (is_branch(kind_e'(slot_kind[k])) && slot_mispredict[k]) begin
              flush_req = 1'b1;
              stop      = 1'b1;
            end
          end else begin
            stop = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/rob_multiport.sv
// Multi-writeback reorder buffer: in-order allocate, out-of-order complete, up to COMMIT_W retires
// per cycle (registered, 1-cycle), store handshake at head, flush pulse on mispredicted branch retire.
module rob_multiport
  import rob_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int NUM_WB   = 2,
  parameter int COMMIT_W = 2,
  parameter int TAG_W    = rob_tag_w(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      issue_valid,
  output logic                      issue_ready,
  input  logic [1:0]                issue_kind,
  input  logic [4:0]                issue_rd,
  input  logic                      issue_pred_taken,
  input  logic [31:0]               issue_pc,
  output logic [TAG_W-1:0]          issue_tag,
  input  logic [2*TAG_W-1:0]        q_tag,
  output logic [1:0]                q_ready,
  output logic [63:0]               q_value,
  input  logic [NUM_WB-1:0]         wb_valid,
  input  logic [NUM_WB*TAG_W-1:0]   wb_tag,
  input  logic [NUM_WB*32-1:0]      wb_value,
  input  logic [NUM_WB-1:0]         wb_taken,
  input  logic [NUM_WB*32-1:0]      wb_aux,
  output logic [COMMIT_W-1:0]       cm_valid,
  output logic [COMMIT_W*5-1:0]     cm_rd,
  output logic [COMMIT_W*32-1:0]    cm_value,
  output logic [COMMIT_W*TAG_W-1:0] cm_tag,
  output logic                      st_valid,
  output logic [31:0]               st_addr,
  output logic [31:0]               st_data,
  output logic [TAG_W-1:0]          st_tag,
  input  logic                      st_ready,
  output logic                      flush,
  output logic [31:0]               flush_pc
);

  localparam int CNT_W = $clog2(COMMIT_W + 1);

  entry_t                     ent_q [DEPTH];
  entry_t                     ent_d [DEPTH];
  logic [TAG_W-1:0]           head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]             count_q, count_d;
  logic [COMMIT_W-1:0]        cm_valid_q, cm_valid_d;
  logic [COMMIT_W*5-1:0]      cm_rd_q, cm_rd_d;
  logic [COMMIT_W*32-1:0]     cm_value_q, cm_value_d;
  logic [COMMIT_W*TAG_W-1:0]  cm_tag_q, cm_tag_d;
  logic                       flush_q, flush_d;
  logic [31:0]                flush_pc_q, flush_pc_d;

  logic                       issue_fire;
  logic [NUM_WB-1:0]          wb_hit;
  logic [COMMIT_W-1:0][TAG_W-1:0] slot_idx;
  logic [COMMIT_W-1:0]        slot_valid, slot_done, slot_mispredict;
  logic [COMMIT_W-1:0][1:0]   slot_kind;
  logic [CNT_W-1:0]           retire_cnt;
  logic                       flush_req, store_retire;

  assign issue_ready = (count_q != (TAG_W+1)'(DEPTH));
  assign issue_tag   = tail_q;
  assign issue_fire  = issue_valid && issue_ready && rdy;

  // Writebacks aimed at entries killed by a flush are dropped here.
  always_comb begin
    wb_hit = '0;
    for (int c = 0; c < NUM_WB; c++)
      wb_hit[c] = wb_valid[c] && ent_q[wb_tag[c*TAG_W +: TAG_W]].valid;
  end

  always_comb begin
    q_ready = '0;
    q_value = '0;
    for (int q = 0; q < 2; q++) begin
      if (ent_q[q_tag[q*TAG_W +: TAG_W]].valid) begin
        if (ent_q[q_tag[q*TAG_W +: TAG_W]].done) begin
          q_ready[q]         = 1'b1;
          q_value[q*32 +: 32] = ent_q[q_tag[q*TAG_W +: TAG_W]].value;
        end else begin
          // Descending scan so the lowest-index matching channel wins.
          for (int c = NUM_WB - 1; c >= 0; c--) begin
            if (wb_valid[c] && wb_tag[c*TAG_W +: TAG_W] == q_tag[q*TAG_W +: TAG_W]) begin
              q_ready[q]          = 1'b1;
              q_value[q*32 +: 32] = wb_value[c*32 +: 32];
            end
          end
        end
      end
    end
  end

  always_comb begin
    slot_idx        = '0;
    slot_valid      = '0;
    slot_done       = '0;
    slot_kind       = '0;
    slot_mispredict = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      slot_idx[k]        = head_q + TAG_W'(k);
      slot_valid[k]      = ent_q[slot_idx[k]].valid;
      slot_done[k]       = ent_q[slot_idx[k]].done;
      slot_kind[k]       = ent_q[slot_idx[k]].kind;
      slot_mispredict[k] = ent_q[slot_idx[k]].taken != ent_q[slot_idx[k]].pred_taken;
    end
  end

  assign st_valid = rdy && ent_q[head_q].valid && ent_q[head_q].done && is_store(ent_q[head_q].kind);
  assign st_addr  = ent_q[head_q].value;
  assign st_data  = ent_q[head_q].aux;
  assign st_tag   = head_q;

  rob_commit_select #(
    .COMMIT_W (COMMIT_W),
    .CNT_W    (CNT_W)
  ) u_commit_select (
    .slot_valid      (slot_valid),
    .slot_done       (slot_done),
    .slot_kind       (slot_kind),
    .slot_mispredict (slot_mispredict),
    .st_ready        (st_ready && rdy),
    .retire_cnt      (retire_cnt),
    .flush_req       (flush_req),
    .store_retire    (store_retire)
  );

  always_comb begin
    ent_d      = ent_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    cm_valid_d = cm_valid_q;
    cm_rd_d    = cm_rd_q;
    cm_value_d = cm_value_q;
    cm_tag_d   = cm_tag_q;
    flush_d    = flush_q;
    flush_pc_d = flush_pc_q;
    if (rdy) begin
      cm_valid_d = '0;
      cm_rd_d    = '0;
      cm_value_d = '0;
      cm_tag_d   = '0;
      flush_d    = 1'b0;
      for (int c = 0; c < NUM_WB; c++) begin
        if (wb_hit[c]) begin
          ent_d[wb_tag[c*TAG_W +: TAG_W]].done  = 1'b1;
          ent_d[wb_tag[c*TAG_W +: TAG_W]].value = wb_value[c*32 +: 32];
          ent_d[wb_tag[c*TAG_W +: TAG_W]].taken = wb_taken[c];
          ent_d[wb_tag[c*TAG_W +: TAG_W]].aux   = wb_aux[c*32 +: 32];
        end
      end
      if (issue_fire) begin
        ent_d[tail_q]            = '0;
        ent_d[tail_q].valid      = 1'b1;
        ent_d[tail_q].kind       = kind_e'(issue_kind);
        ent_d[tail_q].rd         = issue_rd;
        ent_d[tail_q].pred_taken = issue_pred_taken;
        ent_d[tail_q].pc         = issue_pc;
        tail_d                   = tail_q + 1'b1;
      end
      for (int k = 0; k < COMMIT_W; k++) begin
        if (k < int'(retire_cnt)) begin
          ent_d[slot_idx[k]].valid = 1'b0;
          ent_d[slot_idx[k]].done  = 1'b0;
          if (!store_retire) begin
            cm_valid_d[k]             = ent_q[slot_idx[k]].rd != 5'd0;
            cm_rd_d[k*5 +: 5]         = ent_q[slot_idx[k]].rd;
            cm_value_d[k*32 +: 32]    = ent_q[slot_idx[k]].value;
            cm_tag_d[k*TAG_W +: TAG_W] = slot_idx[k];
            if (flush_req && k == int'(retire_cnt) - 1)
              flush_pc_d = ent_q[slot_idx[k]].taken ? ent_q[slot_idx[k]].aux
                                                   : ent_q[slot_idx[k]].pc + 32'd4;
          end
        end
      end
      head_d  = head_q + TAG_W'(retire_cnt);
      count_d = count_q + (TAG_W+1)'(issue_fire) - (TAG_W+1)'(retire_cnt);
      if (flush_req) begin
        flush_d = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
          ent_d[i].valid = 1'b0;
          ent_d[i].done  = 1'b0;
        end
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      cm_valid_q <= '0;
      cm_rd_q    <= '0;
      cm_value_q <= '0;
      cm_tag_q   <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
    end else begin
      ent_q      <= ent_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      cm_valid_q <= cm_valid_d;
      cm_rd_q    <= cm_rd_d;
      cm_value_q <= cm_value_d;
      cm_tag_q   <= cm_tag_d;
      flush_q    <= flush_d;
      flush_pc_q <= flush_pc_d;
    end
  end

  assign cm_valid = cm_valid_q & {COMMIT_W{rdy}};
  assign cm_rd    = cm_rd_q;
  assign cm_value = cm_value_q;
  assign cm_tag   = cm_tag_q;
  assign flush    = flush_q & rdy;
  assign flush_pc = flush_pc_q;

endmodule

// File: tb/tb_rob_multiport.sv
// Directed bench for rob_multiport: fill/full, forwarding, dual commit, mispredict flush, store
// handshake with rdy gating, and continuous issue/retire across the tag wrap.
module tb_rob_multiport;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        issue_valid, issue_ready, issue_pred_taken;
  logic [1:0]  issue_kind;
  logic [4:0]  issue_rd, issue_tag;
  logic [31:0] issue_pc;
  logic [9:0]  q_tag;
  logic [1:0]  q_ready;
  logic [63:0] q_value;
  logic [1:0]  wb_valid, wb_taken;
  logic [9:0]  wb_tag;
  logic [63:0] wb_value, wb_aux;
  logic [1:0]  cm_valid;
  logic [9:0]  cm_rd, cm_tag;
  logic [63:0] cm_value;
  logic        st_valid, st_ready, flush;
  logic [31:0] st_addr, st_data, flush_pc;
  logic [4:0]  st_tag;

  int n_chk = 0;
  int n_err = 0;
  int n_ret = 0;

  always #5 clk = ~clk;

  rob_multiport dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_kind(issue_kind),
    .issue_rd(issue_rd), .issue_pred_taken(issue_pred_taken), .issue_pc(issue_pc),
    .issue_tag(issue_tag), .q_tag(q_tag), .q_ready(q_ready), .q_value(q_value),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value), .wb_taken(wb_taken),
    .wb_aux(wb_aux), .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_value(cm_value),
    .cm_tag(cm_tag), .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .st_tag(st_tag), .st_ready(st_ready), .flush(flush), .flush_pc(flush_pc)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    issue_valid = 0; issue_kind = 0; issue_rd = 0; issue_pred_taken = 0; issue_pc = 0;
    q_tag = 0; wb_valid = 0; wb_tag = 0; wb_value = 0; wb_taken = 0; wb_aux = 0; st_ready = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic do_issue(input logic [1:0] k, input logic [4:0] rd, input logic p, input logic [31:0] pc);
    issue_valid = 1; issue_kind = k; issue_rd = rd; issue_pred_taken = p; issue_pc = pc;
    step();
  endtask

  task automatic set_wb(input int ch, input logic [4:0] tag, input logic [31:0] v,
                        input logic tk, input logic [31:0] aux);
    wb_valid[ch] = 1'b1; wb_tag[ch*5 +: 5] = tag; wb_value[ch*32 +: 32] = v;
    wb_taken[ch] = tk;   wb_aux[ch*32 +: 32] = aux;
  endtask

  task automatic do_reset();
    rst = 1; step(); step(); rst = 0;
  endtask

  task automatic collect();
    for (int k = 0; k < 2; k++) begin
      if (cm_valid[k]) begin
        check("wrap_tag", cm_tag[k*5 +: 5], 64'((2 + n_ret) % 32));
        check("wrap_val", cm_value[k*32 +: 32], 64'(32'h1000 + n_ret));
        check("wrap_rd",  cm_rd[k*5 +: 5], 64'((n_ret % 31) + 1));
        n_ret++;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rdy = 1;
    clear_inputs();
    do_reset();

    check("rst_issue_ready", issue_ready, 1);
    check("rst_issue_tag", issue_tag, 0);
    check("rst_cm_valid", cm_valid, 0);
    check("rst_flush", flush, 0);
    check("rst_flush_pc", flush_pc, 0);
    check("rst_st_valid", st_valid, 0);
    q_tag = {5'd7, 5'd7}; #1;
    check("rst_q_ready", q_ready, 0);
    check("rst_q_value", q_value, 0);

    // Fill all 32 entries with no writebacks.
    for (int i = 0; i < 32; i++) begin
      issue_valid = 1; issue_kind = 2'd0; issue_rd = 5'd1; issue_pc = 32'(i * 4);
      #1;
      if (i == 0 || i == 31) check("fill_tag", issue_tag, 64'(i));
      step();
    end
    check("full_ready", issue_ready, 0);
    check("full_tail", issue_tag, 0);
    q_tag = {5'd4, 5'd3}; #1;
    check("q_not_done", q_ready, 2'b00);
    set_wb(0, 5'd3, 32'h1234, 0, 0);
    set_wb(1, 5'd4, 32'h55, 0, 0);
    issue_valid = 1; issue_kind = 2'd0; issue_rd = 5'd1;
    #1;
    check("q_fwd_ready", q_ready, 2'b11);
    check("q_fwd_value", q_value, {32'h55, 32'h1234});
    step();
    check("full_33_tag", issue_tag, 0);
    check("full_33_ready", issue_ready, 0);
    q_tag = {5'd5, 5'd3};
    set_wb(0, 5'd3, 32'h9999, 0, 0);
    #1;
    check("q_stored_ready", q_ready, 2'b01);
    check("q_stored_value", q_value, {32'h0, 32'h1234});
    step();
    check("full_no_commit", cm_valid, 0);
    do_reset();

    // Out-of-order completion, in-order dual commit.
    do_issue(2'd0, 5'd3, 0, 32'h0);
    do_issue(2'd0, 5'd4, 0, 32'h4);
    set_wb(1, 5'd1, 32'hBB, 0, 0); step();
    check("ooo_hold", cm_valid, 0);
    set_wb(0, 5'd0, 32'hAA, 0, 0); step();
    check("ooo_hold2", cm_valid, 0);
    step();
    check("dual_valid", cm_valid, 2'b11);
    check("dual_value", cm_value, {32'hBB, 32'hAA});
    check("dual_rd", cm_rd, {5'd4, 5'd3});
    check("dual_tag", cm_tag, {5'd1, 5'd0});
    rdy = 0; #1;
    check("rdy_low_cm", cm_valid, 0);
    rdy = 1; #1;
    check("rdy_back_cm", cm_valid, 2'b11);
    step();
    check("dual_done", cm_valid, 0);
    check("dual_tail", issue_tag, 2);

    // Mispredicted branch at tag 5 with younger ALU at tag 6.
    do_issue(2'd0, 5'd5, 0, 32'h8);
    do_issue(2'd0, 5'd5, 0, 32'hC);
    do_issue(2'd0, 5'd5, 0, 32'h10);
    do_issue(2'd1, 5'd0, 0, 32'h40);
    do_issue(2'd0, 5'd7, 0, 32'h44);
    set_wb(0, 5'd2, 32'h22, 0, 0); set_wb(1, 5'd3, 32'h33, 0, 0); step();
    set_wb(0, 5'd4, 32'h44, 0, 0); set_wb(1, 5'd5, 32'h0, 1, 32'h100); step();
    check("pre_br_valid", cm_valid, 2'b11);
    check("pre_br_tag", cm_tag, {5'd3, 5'd2});
    check("pre_br_value", cm_value, {32'h33, 32'h22});
    set_wb(0, 5'd6, 32'h66, 0, 0); step();
    check("flush_pulse", flush, 1);
    check("flush_pc", flush_pc, 32'h100);
    check("br_grp_valid", cm_valid, 2'b01);
    check("br_grp_tag0", cm_tag[4:0], 4);
    check("br_grp_val0", cm_value[31:0], 32'h44);
    check("flush_tail", issue_tag, 0);
    q_tag = {5'd6, 5'd6}; #1;
    check("flush_q_dead", q_ready, 0);
    step();
    check("flush_one_cycle", flush, 0);
    check("tag6_not_committed", cm_valid, 0);
    check("flush_ready", issue_ready, 1);

    // Store at head waits for st_ready; rdy low blocks the handshake.
    do_issue(2'd3, 5'd0, 0, 32'h80);
    do_issue(2'd0, 5'd9, 0, 32'h84);
    set_wb(0, 5'd0, 32'hA000, 0, 32'hD0D0); set_wb(1, 5'd1, 32'h11, 0, 0); step();
    check("st_valid", st_valid, 1);
    check("st_addr", st_addr, 32'hA000);
    check("st_data", st_data, 32'hD0D0);
    check("st_tag", st_tag, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("st_stall_valid", st_valid, 1);
      check("st_stall_tag", st_tag, 0);
      check("st_stall_cm", cm_valid, 0);
    end
    rdy = 0; st_ready = 1; #1;
    check("st_rdy_low", st_valid, 0);
    step();
    rdy = 1; #1;
    check("st_still_head", st_valid, 1);
    check("st_still_tag", st_tag, 0);
    st_ready = 1; step();
    check("st_no_cm_slot", cm_valid, 0);
    check("st_gone", st_valid, 0);
    step();
    check("post_st_valid", cm_valid, 2'b01);
    check("post_st_tag", cm_tag[4:0], 1);
    check("post_st_value", cm_value[31:0], 32'h11);
    check("post_st_tail", issue_tag, 2);

    // Continuous issue/writeback/retire across the 31 -> 0 tag wrap.
    for (int i = 0; i < 44; i++) begin
      if (i < 40) begin
        issue_valid = 1; issue_kind = 2'd0; issue_rd = 5'((i % 31) + 1); issue_pc = 32'(i * 4);
      end
      if (i >= 1 && i <= 40)
        set_wb(0, 5'((2 + i - 1) % 32), 32'h1000 + 32'(i - 1), 0, 0);
      step();
      collect();
    end
    check("wrap_count", n_ret, 40);
    check("wrap_tail", issue_tag, 10);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/rob_multiport.md
Name: rob_multiport

Overview:
- Parametrised reorder buffer; successor to the single-writeback, single-commit ROB.
- Allocates in-order tags at issue and accepts out-of-order results on NUM_WB writeback channels.
- Forwards operands to issue, retires up to COMMIT_W entries per cycle to the register file, and hands stores to the LSB by handshake.
- Raises a one-cycle flush with redirect PC on branch mispredict.

Parameters:
- DEPTH, 32, number of entries; power of two, at least 4.
- NUM_WB, 2, writeback channels (ch0 ALU, ch1 load unit).
- COMMIT_W, 2, maximum retirements per cycle, 1..4.
- TAG_W, $clog2(DEPTH), entry index width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- rdy  in  1  global enable; low = hold all state
- issue_valid  in  1  allocate an entry
- issue_ready  out  1  !full
- issue_kind  in  2  0 ALU, 1 BRANCH, 2 LOAD, 3 STORE
- issue_rd  in  5  destination register (0 = none)
- issue_pred_taken  in  1  predicted direction
- issue_pc  in  32  instruction PC
- issue_tag  out  TAG_W  tag being allocated (= tail)
- q_tag  in  2*TAG_W  two operand lookup tags
- q_ready  out  2  operand available
- q_value  out  64  operand values
- wb_valid  in  NUM_WB  result strobe per channel
- wb_tag  in  NUM_WB*TAG_W  target entry
- wb_value  in  NUM_WB*32  result (STORE: address)
- wb_taken  in  NUM_WB  resolved direction
- wb_aux  in  NUM_WB*32  branch target / store data
- cm_valid  out  COMMIT_W  RF write slots, registered
- cm_rd  out  COMMIT_W*5  destination per slot
- cm_value  out  COMMIT_W*32  value per slot
- cm_tag  out  COMMIT_W*TAG_W  tag per slot (RF clears rename if match)
- st_valid  out  1  head store offered to LSB
- st_addr  out  32  store address
- st_data  out  32  store data
- st_tag  out  TAG_W  store tag
- st_ready  in  1  LSB accepts store
- flush  out  1  mispredict pulse
- flush_pc  out  32  redirect PC

Behaviour:
- Reset: head = tail = count = 0; all entry valid/done = 0; cm_valid = 0, flush = 0, flush_pc = 0; st_valid derived combinationally, so 0.
- Storage: circular; head/tail wrap DEPTH-1 -> 0; count is TAG_W+1 bits; full when count == DEPTH.
- Issue: accepted when issue_valid && issue_ready && rdy. Entry is written valid=1, done=0; tail increments; issue_tag = tail. There is no same-cycle retire bypass: a full ROB refuses issue even if a commit occurs that cycle.
- Writeback: for each channel with wb_valid whose tag addresses a valid entry, set done and store value, taken and aux. A writeback to an invalid entry (stale after flush) is ignored. Two channels never target the same tag; behaviour in that case is undefined.
- Forwarding (combinational): q_ready = entry valid && (done || same-cycle wb match on any channel). Value priority: stored result, then lowest-index matching channel. Entry kind LOAD is forwarded identically (no load exclusion). An invalid entry gives q_ready = 0 and q_value = 0.
- Commit select (combinational):
  - Slot k retires iff slots 0..k-1 retire, entry head+k is valid and done, kind != STORE, and no earlier slot is a mispredicted BRANCH.
  - A mispredicted BRANCH retires as the last slot of its group.
  - Mispredict is defined as taken != pred_taken.
- Store: when head is a valid, done STORE, st_valid = 1 with st_addr = value, st_data = aux, st_tag = head. It retires alone (slot 0) in the cycle st_ready = 1; no cm slot is used.
- Retire update at the clock edge:
  - head += n, count += accepted_issue - n, valid cleared on retired entries.
  - cm_* registered, one-cycle latency; cm_valid[k] is set only when rd != 0.
- Flush:
  - The cycle a mispredicted BRANCH retires, the next edge sets flush = 1 and flush_pc = taken ? aux : pc+4.
  - At that same edge all entries are invalidated and head = tail = count = 0.
  - Issue and writebacks in that cycle are discarded.
  - flush is a 1-cycle pulse.
- rdy low: no state change; cm_valid and flush are driven to 0; st_valid is forced to 0.
- rst overrides everything, including a pending flush.

Decomposition:
- rob_pkg: issue_kind encodings, kind-predicate functions, a TAG_W helper function.
- Sub-module rob_commit_select: combinational; inputs are per-slot valid/done/kind/mispredict, outputs are retire count and flush-request.

Test Plan:
- Fill 32 ALU issues, no writeback -> issue_ready = 0 at count 32; 33rd issue ignored, tail stays 0.
- Issue tags 0,1; ch1 writes tag1 = 0xBB, then ch0 writes tag0 = 0xAA -> next cycle cm_valid = 2'b11, values AA, BB in order.
- Query tag 3 while ch0 writes tag 3 = 0x1234 the same cycle -> q_ready = 1, q_value = 0x1234.
- BRANCH at tag 5 (pred 0), wb taken = 1, aux = 0x100; ALU tag 6 done -> flush pulse, flush_pc = 0x100, tag 6 not committed, count = 0.
- STORE at head done, st_ready held 0 for 3 cycles -> st_valid high, head stalls; st_ready = 1 -> retire, head + 1.
- Wrap: issue and retire 40 entries continuously -> tags wrap 31 -> 0, commit order is preserved.
